// File: rtl/branch_resolve_unit.sv
// EX-stage branch/JAL/JALR resolution with a direct-mapped BTB (2-bit counters)
// read combinationally by IF and trained at the clock edge, plus trace counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1_data,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            is_control_hazard,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        branch_count_q, branch_count_d;
    logic [31:0]        mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             unused_if_pc_lsbs;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
    assign unused_if_pc_lsbs = ^if_pc[1:0];

    // No write-to-read bypass: IF always sees the registered BTB contents.
    assign if_hit         = ~rst & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit & ctr_q[if_idx][1];
    assign if_pred_target = if_hit ? target_q[if_idx] : '0;

    logic            eq, lt_s, lt_u, br_cf, br_taken, cf, taken;
    logic [XLEN-1:0] jalr_sum, target, next_pc;

    assign eq   = (ex_rs1_data == ex_rs2_data);
    assign lt_s = ($signed(ex_rs1_data) < $signed(ex_rs2_data));
    assign lt_u = (ex_rs1_data < ex_rs2_data);

    always_comb begin
        br_cf    = 1'b1;
        br_taken = 1'b0;
        case (ex_funct3)
            3'b000:  br_taken = eq;
            3'b001:  br_taken = ~eq;
            3'b100:  br_taken = lt_s;
            3'b101:  br_taken = ~lt_s;
            3'b110:  br_taken = lt_u;
            3'b111:  br_taken = ~lt_u;
            default: br_cf    = 1'b0;
        endcase
    end

    assign cf       = ex_is_jal | ex_is_jalr | (ex_is_branch & br_cf);
    assign taken    = ex_is_jal | ex_is_jalr | (ex_is_branch & br_cf & br_taken);
    assign jalr_sum = ex_rs1_data + ex_imm;
    assign target   = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
    assign next_pc  = taken ? target : ex_pc + XLEN'(4);

    // A non-control-flow instruction that IF predicted taken must also be undone.
    assign is_control_hazard = ex_valid & (cf ? ((taken != ex_pred_taken) |
                                                 (taken & (ex_pred_target != target)))
                                              : ex_pred_taken);
    assign redirect_pc = next_pc;

    logic            wr_en;
    logic [1:0]      ctr_d;
    logic [XLEN-1:0] target_d;

    assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

    always_comb begin
        wr_en    = 1'b0;
        ctr_d    = ctr_q[ex_idx];
        target_d = target_q[ex_idx];
        if (ex_valid & cf) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (taken) begin
                    ctr_d    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                    target_d = target;
                end else begin
                    ctr_d    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (taken) begin
                wr_en    = 1'b1;
                ctr_d    = 2'b10;
                target_d = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= target_d;
            ctr_q[ex_idx]    <= ctr_d;
        end
    end

    assign branch_count_d     = branch_count_q + 32'((ex_valid & cf) ? 1 : 0);
    assign mispredict_count_d = mispredict_count_q + 32'(is_control_hazard ? 1 : 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic compared against an array-based BTB/statistics model.
module tb_branch_resolve_unit;
    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        is_control_hazard;
    logic [31:0] redirect_pc, branch_count, mispredict_count;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .is_control_hazard(is_control_hazard), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 16-entry BTB as plain arrays, counters as integers 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_bc, m_mc;

    bit          s_cf, s_tk, s_hz;
    logic [31:0] s_tgt, s_npc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tgt);
        int idx = int'((pc >> 2) & 32'hF);
        bit hit = m_valid[idx] && (m_tag[idx] == (pc >> 6));
        pt  = hit && (m_ctr[idx] >= 2);
        tgt = hit ? m_tgt[idx] : 32'h0;
    endfunction

    function automatic void model_train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        int idx = int'((pc >> 2) & 32'hF);
        if (m_valid[idx] && m_tag[idx] == (pc >> 6)) begin
            if (tk) begin
                if (m_ctr[idx] < 3) m_ctr[idx]++;
                m_tgt[idx] = tgt;
            end else if (m_ctr[idx] > 0) begin
                m_ctr[idx]--;
            end
        end else if (tk) begin
            m_valid[idx] = 1; m_tag[idx] = pc >> 6; m_tgt[idx] = tgt; m_ctr[idx] = 2;
        end
    endfunction

    function automatic void model_eval();
        s_cf = 0; s_tk = 0;
        if (ex_is_jal || ex_is_jalr) begin
            s_cf = 1; s_tk = 1;
        end else if (ex_is_branch) begin
            case (ex_funct3)
                3'd0: begin s_cf = 1; s_tk = (ex_rs1_data == ex_rs2_data); end
                3'd1: begin s_cf = 1; s_tk = (ex_rs1_data != ex_rs2_data); end
                3'd4: begin s_cf = 1; s_tk = ($signed(ex_rs1_data) <  $signed(ex_rs2_data)); end
                3'd5: begin s_cf = 1; s_tk = ($signed(ex_rs1_data) >= $signed(ex_rs2_data)); end
                3'd6: begin s_cf = 1; s_tk = (ex_rs1_data <  ex_rs2_data); end
                3'd7: begin s_cf = 1; s_tk = (ex_rs1_data >= ex_rs2_data); end
                default: s_cf = 0;
            endcase
        end
        s_tgt = ex_is_jalr ? ((ex_rs1_data + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
        s_npc = s_tk ? s_tgt : ex_pc + 32'd4;
        if (!ex_valid)  s_hz = 0;
        else if (s_cf)  s_hz = (s_tk != ex_pred_taken) || (s_tk && ex_pred_target != s_tgt);
        else            s_hz = ex_pred_taken;
    endfunction

    task automatic set_ex(input bit v, input bit br, input bit jal, input bit jalr,
                          input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit pt, input logic [31:0] ptgt);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1_data = a; ex_rs2_data = b;
        ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    // Settle to the falling edge and compare every output against the model.
    task automatic eval_cycle();
        bit          pt;
        logic [31:0] ptgt;
        #4;
        model_eval();
        model_lookup(if_pc, pt, ptgt);
        check_eq("if_pred_taken", 32'(if_pred_taken), rst ? 32'h0 : 32'(pt));
        if (!rst) begin
            check_eq("if_pred_target", if_pred_target, ptgt);
            check_eq("hazard", 32'(is_control_hazard), 32'(s_hz));
            if (s_hz) check_eq("redirect_pc", redirect_pc, s_npc);
        end
        check_eq("branch_count", branch_count, m_bc);
        check_eq("mispredict_count", mispredict_count, m_mc);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (ex_valid && s_cf) begin
                m_bc++;
                model_train(ex_pc, s_tk, s_tgt);
            end
            if (s_hz) m_mc++;
        end
        #1;
    endtask

    initial begin
        bit          pt;
        logic [31:0] ptgt;
        logic [31:0] pcs [4];
        int          typ;

        rst = 1'b1; if_pc = 32'h100;
        set_ex(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;

        // Cold start: BEQ taken, not predicted
        if_pc = 32'h100;
        set_ex(1, 1, 0, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 0, 32'h0);
        eval_cycle();
        check_eq("t1_cold_pred", 32'(if_pred_taken), 32'h0);
        check_eq("t1_cold_bc", branch_count, 32'h0);
        check_eq("t1_hazard", 32'(is_control_hazard), 32'h1);
        check_eq("t1_redirect", redirect_pc, 32'h120);
        tick();

        // Counter training
        set_ex(1, 1, 0, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1, 32'h120);
        eval_cycle();
        check_eq("t1_alloc_pred", 32'(if_pred_taken), 32'h1);
        check_eq("t1_alloc_tgt", if_pred_target, 32'h120);
        check_eq("t1_bc", branch_count, 32'h1);
        check_eq("t1_mc", mispredict_count, 32'h1);
        check_eq("t2_correct", 32'(is_control_hazard), 32'h0);
        tick();
        set_ex(1, 1, 0, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd6, 1, 32'h120);
        eval_cycle();
        check_eq("t2_nt_hazard", 32'(is_control_hazard), 32'h1);
        check_eq("t2_nt_redirect", redirect_pc, 32'h104);
        tick();
        eval_cycle();
        check_eq("t2_nt2_hazard", 32'(is_control_hazard), 32'h1);
        check_eq("t2_still_pred", 32'(if_pred_taken), 32'h1);
        tick();
        set_ex(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        eval_cycle();
        check_eq("t2_weak_pred", 32'(if_pred_taken), 32'h0);
        tick();

        // Signed vs unsigned compares
        if_pc = 32'h200;
        set_ex(1, 1, 0, 0, 3'd4, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        eval_cycle();
        check_eq("t3_blt_hazard", 32'(is_control_hazard), 32'h1);
        check_eq("t3_blt_redirect", redirect_pc, 32'h210);
        tick();
        set_ex(1, 1, 0, 0, 3'd6, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        eval_cycle();
        check_eq("t3_bltu_hazard", 32'(is_control_hazard), 32'h0);
        tick();
        set_ex(1, 1, 0, 0, 3'd7, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        eval_cycle();
        check_eq("t3_bgeu_hazard", 32'(is_control_hazard), 32'h1);
        check_eq("t3_bgeu_redirect", redirect_pc, 32'h210);
        tick();

        // JALR with wrong predicted target
        if_pc = 32'h300;
        set_ex(1, 0, 0, 1, 3'd0, 32'h300, 32'h0, 32'h2003, 32'h0, 1, 32'h2000);
        eval_cycle();
        check_eq("t4_jalr_hazard", 32'(is_control_hazard), 32'h1);
        check_eq("t4_jalr_redirect", redirect_pc, 32'h2002);
        tick();
        set_ex(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        eval_cycle();
        check_eq("t4_btb_tgt", if_pred_target, 32'h2002);
        tick();

        // Aliasing at index 0 and a non-cf instruction predicted taken
        set_ex(1, 1, 0, 0, 3'd0, 32'h100, 32'h20, 32'd7, 32'd7, 0, 32'h0);
        eval_cycle();
        tick();
        if_pc = 32'h140;
        set_ex(1, 1, 0, 0, 3'd0, 32'h140, 32'h40, 32'd9, 32'd9, 0, 32'h0);
        eval_cycle();
        check_eq("t5_alias_pred", 32'(if_pred_taken), 32'h0);
        tick();
        if_pc = 32'h100;
        set_ex(1, 1, 0, 0, 3'd2, 32'h400, 32'h0, 32'h0, 32'h0, 1, 32'h480);
        eval_cycle();
        check_eq("t5_replaced_pred", 32'(if_pred_taken), 32'h0);
        check_eq("t5_noncf_hazard", 32'(is_control_hazard), 32'h1);
        check_eq("t5_noncf_redirect", redirect_pc, 32'h404);
        tick();

        // Bubble with mismatching prediction, then reset
        if_pc = 32'h140;
        set_ex(0, 0, 1, 0, 3'd0, 32'h500, 32'h40, 32'h0, 32'h0, 1, 32'h0);
        eval_cycle();
        check_eq("t6_bubble_hazard", 32'(is_control_hazard), 32'h0);
        check_eq("t6_trained_pred", 32'(if_pred_taken), 32'h1);
        tick();
        eval_cycle();
        tick();
        rst = 1'b1;
        eval_cycle();
        tick();
        rst = 1'b0;
        set_ex(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        eval_cycle();
        check_eq("t6_rst_bc", branch_count, 32'h0);
        check_eq("t6_rst_mc", mispredict_count, 32'h0);
        pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h200; pcs[3] = 32'h300;
        for (int i = 0; i < 4; i++) begin
            if_pc = pcs[i];
            #1;
            check_eq("t6_rst_pred", 32'(if_pred_taken), 32'h0);
        end
        tick();

        // Randomized traffic over a small PC window so entries collide and train
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            typ = int'($urandom_range(0, 9));
            ex_valid     = ($urandom_range(0, 9) != 0);
            ex_is_branch = (typ <= 5);
            ex_is_jal    = (typ == 6);
            ex_is_jalr   = (typ == 7);
            ex_funct3    = 3'($urandom_range(0, 7));
            ex_pc = 32'h1000 | 32'($urandom_range(0, 3) << 6) | 32'($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 1) == 0) if_pc = ex_pc;
            else if_pc = 32'h1000 | 32'($urandom_range(0, 3) << 6) | 32'($urandom_range(0, 15) << 2);
            ex_imm = 32'($signed(8'($urandom_range(0, 255))));
            case ($urandom_range(0, 4))
                0: ex_rs1_data = 32'h0;
                1: ex_rs1_data = 32'h1;
                2: ex_rs1_data = 32'hFFFF_FFFF;
                3: ex_rs1_data = 32'h8000_0000;
                default: ex_rs1_data = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: ex_rs2_data = 32'h0;
                1: ex_rs2_data = 32'h1;
                2: ex_rs2_data = 32'hFFFF_FFFF;
                3: ex_rs2_data = ex_rs1_data;
                default: ex_rs2_data = $urandom;
            endcase
            if ($urandom_range(0, 2) != 0) begin
                model_lookup(ex_pc, pt, ptgt);
                ex_pred_taken = pt; ex_pred_target = ptgt;
            end else begin
                ex_pred_taken  = 1'($urandom_range(0, 1));
                ex_pred_target = ex_pc + 32'($urandom_range(0, 3) << 2);
            end
            eval_cycle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
